alu_result_display: RTL and testbench

Sequential output stage for the 4-bit ALU on the Basys 3 board. It reads the 8-bit ALU result bus (the same value driven onto `led[7:0]`) and converts it to three BCD digits with a sequential double-dabble FSM. It then drives the board's 4-digit multiplexed seven-segment display, so the result appears in decimal next to the binary LED view.

---
 rtl/alu_result_display.sv | 133 +++++++++++++
 tb/tb_alu_result_display.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/alu_result_display.sv
// Converts the 8-bit ALU result to decimal with a sequential double-dabble FSM and
// drives the 4-digit multiplexed seven-segment display with leading-zero blanking.
module alu_result_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] result,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam int          DIV_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [3:0]  BLANK   = 4'hF;

  logic [1:0]       state;
  logic [7:0]       cap_val;
  logic [19:0]      shreg;
  logic [19:0]      adj;
  logic [2:0]       bit_cnt;
  logic [3:0]       disp_h, disp_t, disp_u;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       dig_idx;
  logic [3:0]       cur_digit;
  logic [6:0]       cur_seg;

  // Add-3 correction on each BCD nibble before the shift.
  always_comb begin
    adj = shreg;
    if (shreg[19:16] >= 4'd5) adj[19:16] = shreg[19:16] + 4'd3;
    if (shreg[15:12] >= 4'd5) adj[15:12] = shreg[15:12] + 4'd3;
    if (shreg[11:8]  >= 4'd5) adj[11:8]  = shreg[11:8]  + 4'd3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cap_val <= 8'd0;
      shreg   <= 20'd0;
      bit_cnt <= 3'd0;
      busy    <= 1'b0;
      disp_h  <= 4'd0;
      disp_t  <= 4'd0;
      disp_u  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (result != cap_val) begin
            cap_val <= result;
            shreg   <= {12'd0, result};
            bit_cnt <= 3'd0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          shreg   <= {adj[18:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= DONE;
        end
        DONE: begin
          disp_h <= shreg[19:16];
          disp_t <= shreg[15:12];
          disp_u <= shreg[11:8];
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      dig_idx <= 2'd0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      dig_idx <= dig_idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Interior zeros stay visible; only leading zeros above the units are blanked.
  always_comb begin
    cur_digit = BLANK;
    case (dig_idx)
      2'd0: cur_digit = disp_u;
      2'd1: cur_digit = (disp_h == 4'd0 && disp_t == 4'd0) ? BLANK : disp_t;
      2'd2: cur_digit = (disp_h == 4'd0) ? BLANK : disp_h;
      default: cur_digit = BLANK;
    endcase
  end

  always_comb begin
    cur_seg = 7'b1111111;
    case (cur_digit)
      4'd0: cur_seg = 7'b1000000;
      4'd1: cur_seg = 7'b1111001;
      4'd2: cur_seg = 7'b0100100;
      4'd3: cur_seg = 7'b0110000;
      4'd4: cur_seg = 7'b0011001;
      4'd5: cur_seg = 7'b0010010;
      4'd6: cur_seg = 7'b0000010;
      4'd7: cur_seg = 7'b1111000;
      4'd8: cur_seg = 7'b0000000;
      4'd9: cur_seg = 7'b0010000;
      default: cur_seg = 7'b1111111;
    endcase
  end

  // Anode and cathodes are registered together so a digit never shows another's pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      an  <= ~(4'b0001 << dig_idx);
      seg <= cur_seg;
      dp  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_result_display.sv
// Scoreboarded bench: stimulus queues accepted values, a per-cycle monitor checks the
// scanned display against a decimal model of the currently shown value.
module tb_alu_result_display;

  localparam int RD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] result = 8'd0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       busy;

  alu_result_display #(.REFRESH_DIV(RD)) dut (
    .clk    (clk),
    .rst    (rst),
    .result (result),
    .seg    (seg),
    .dp     (dp),
    .an     (an),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int unsigned exp_q[$];
  int unsigned model_cap = 0;
  int unsigned disp_model = 0;
  int          n = 0;
  int          n_rise = 0;
  logic        prev_busy = 1'b0;

  logic [6:0] seg_tab [0:10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b1111111};

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, actual, actual, expected, expected, $time);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int unsigned val, input int idx);
    int unsigned h, t, u;
    h = val / 100;
    t = (val / 10) % 10;
    u = val % 10;
    case (idx)
      0: exp_seg = seg_tab[u];
      1: exp_seg = (h == 0 && t == 0) ? seg_tab[10] : seg_tab[t];
      2: exp_seg = (h == 0) ? seg_tab[10] : seg_tab[h];
      default: exp_seg = seg_tab[10];
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) n = 0;
    else n = n + 1;
  end

  // Monitor: compares the scanned digit every cycle, retires expectations on busy fall.
  always @(negedge clk) begin
    if (rst) begin
      prev_busy  = 1'b0;
      disp_model = 0;
    end else if (n > 0) begin
      int idx;
      idx = ((n - 1) / RD) % 4;
      check("an", int'(an), int'(~(4'b0001 << idx) & 4'hF));
      check("seg", int'(seg), int'(exp_seg(disp_model, idx)));
      check("dp", int'(dp), 1);
      if (busy && !prev_busy) begin
        n_rise = n;
        if (exp_q.size() == 0) check("unexpected_busy", 1, 0);
      end
      if (!busy && prev_busy) begin
        check("busy_len", n - n_rise, 9);
        if (exp_q.size() == 0) check("unexpected_done", 1, 0);
        else disp_model = exp_q.pop_front();
      end
      prev_busy = busy;
    end
  end

  task automatic apply(input int unsigned v, input int wait_cycles);
    @(posedge clk);
    #1;
    result = v[7:0];
    if (v != model_cap) begin
      exp_q.push_back(v);
      model_cap = v;
    end
    repeat (wait_cycles) @(posedge clk);
  endtask

  task automatic check_reset_outputs();
    check("rst_an", int'(an), 4'b1111);
    check("rst_seg", int'(seg), 7'b1111111);
    check("rst_dp", int'(dp), 1);
    check("rst_busy", int'(busy), 0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 check_reset_outputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Idle scan with result 0: display "0", no conversion.
    repeat (40) @(posedge clk);

    apply(255, 30);
    apply(9, 30);
    apply(100, 30);

    // Second value arrives mid-conversion and is picked up afterwards.
    apply(37, 3);
    apply(200, 40);

    // Reset during a conversion of 128.
    apply(128, 3);
    #1 rst = 1'b1;
    #1 check_reset_outputs();
    exp_q.delete();
    model_cap = 0;
    exp_q.push_back(128);
    model_cap = 128;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(posedge clk);

    for (int i = 0; i < 20; i++) apply($urandom_range(0, 255), 30);
    for (int v = 0; v < 256; v++) apply(v, 26);

    repeat (30) @(posedge clk);
    check("pending_conversions", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
